// File: rtl/io_block_loader_if.sv
// rtl/io_block_loader_if.sv - Signal bundle linking the block loader to the input device and the memory
interface io_block_loader_if;
  logic        start;
  logic [11:0] start_addr;
  logic [11:0] word_count;
  logic        digit_valid;
  logic [2:0]  digit;
  logic        digit_ready;
  logic        mem_write_to_mem;
  logic        mem_write_reply_from_mem;
  logic [11:0] addr_to_sel;
  logic        write_sign_to_mem;
  logic [29:0] write_data_to_mem;
  logic        busy;
  logic        done;
  logic [30:0] checksum;

  // Loader side: drives the memory write request and the digit handshake ready.
  modport master (
    input  start, start_addr, word_count, digit_valid, digit, mem_write_reply_from_mem,
    output digit_ready, mem_write_to_mem, addr_to_sel, write_sign_to_mem,
           write_data_to_mem, busy, done, checksum
  );

  // Environment side: input device, memory and whoever issues start.
  modport slave (
    output start, start_addr, word_count, digit_valid, digit, mem_write_reply_from_mem,
    input  digit_ready, mem_write_to_mem, addr_to_sel, write_sign_to_mem,
           write_data_to_mem, busy, done, checksum
  );
endinterface

// File: rtl/io_block_loader.sv
// rtl/io_block_loader.sv - Octal digit block loader writing 31-bit words into consecutive memory cells (option: IO_BLOCK_LOADER_CHECKSUM_EN)
module io_block_loader (
  input  logic              clk,
  input  logic              resetn,
  io_block_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ASSEMBLE = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_addr;
  logic [11:0] r_remaining;
  logic [3:0]  r_idx;
  logic        r_sign;
  logic [29:0] r_data;

  logic w_digit_ready;
  logic w_write;
  logic w_busy;
  logic w_done;
  logic w_accept;
  logic w_start_ok;
  logic w_reply;
  logic w_last_digit;
  logic w_last_word;

  assign w_accept     = w_digit_ready & bus.digit_valid;
  assign w_start_ok   = (r_state == S_IDLE) & bus.start;
  assign w_reply      = (r_state == S_WAIT) & bus.mem_write_reply_from_mem;
  assign w_last_digit = (r_idx == 4'd10);
  assign w_last_word  = (r_remaining == 12'd1);

  // State register; reset drops straight to IDLE so no request can follow an abort.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state selection; a reply only matters while waiting for one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (bus.word_count == 12'd0) ? S_DONE : S_ASSEMBLE;
      end
      S_ASSEMBLE: begin
        if (w_accept && w_last_digit) w_next = S_REQ;
      end
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (bus.mem_write_reply_from_mem) w_next = w_last_word ? S_DONE : S_ASSEMBLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded purely from the current state.
  always_comb begin
    w_digit_ready = 1'b0;
    w_write       = 1'b0;
    w_busy        = 1'b1;
    w_done        = 1'b0;
    case (r_state)
      S_IDLE:     w_busy        = 1'b0;
      S_ASSEMBLE: w_digit_ready = 1'b1;
      S_REQ:      w_write       = 1'b1;
      S_DONE:     w_done        = 1'b1;
      default:    ;
    endcase
  end

  // Address, word counter and word assembly; digit 0 carries the sign, digits 1-10 shift in MSD first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= 12'd0;
      r_remaining <= 12'd0;
      r_idx       <= 4'd0;
      r_sign      <= 1'b0;
      r_data      <= 30'd0;
    end else begin
      if (w_start_ok && (bus.word_count != 12'd0)) begin
        r_addr      <= bus.start_addr;
        r_remaining <= bus.word_count;
        r_idx       <= 4'd0;
      end
      if (w_accept) begin
        r_idx <= r_idx + 4'd1;
        if (r_idx == 4'd0) r_sign <= bus.digit[0];
        else               r_data <= {r_data[26:0], bus.digit};
      end
      if (w_reply) begin
        r_remaining <= r_remaining - 12'd1;
        r_addr      <= r_addr + 12'd1;
        r_idx       <= 4'd0;
      end
    end
  end

`ifdef IO_BLOCK_LOADER_CHECKSUM_EN
  logic [30:0] r_checksum;

  // Running sum of written words, restarted by every accepted start and frozen in IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         r_checksum <= 31'd0;
    else if (w_start_ok) r_checksum <= 31'd0;
    else if (w_reply)    r_checksum <= r_checksum + {r_sign, r_data};
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = 31'd0;
`endif

  assign bus.digit_ready       = w_digit_ready;
  assign bus.mem_write_to_mem  = w_write;
  assign bus.busy              = w_busy;
  assign bus.done              = w_done;
  assign bus.addr_to_sel       = r_addr;
  assign bus.write_sign_to_mem = r_sign;
  assign bus.write_data_to_mem = r_data;

endmodule

// File: tb/tb_io_block_loader.sv
// tb/tb_io_block_loader.sv - Scoreboard bench for io_block_loader with a two-cycle reply memory model
`timescale 1ns/1ps
module tb_io_block_loader;
  logic clk = 1'b0;
  logic resetn;
  logic auto_reply;
  logic manual_reply;

  io_block_loader_if bus();

  io_block_loader dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_write_reply_from_mem = auto_reply | manual_reply;

  typedef struct packed {
    logic [11:0] addr;
    logic        sign;
    logic [29:0] data;
  } word_t;

  word_t       sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          req_cyc = -100;
  int          req_cnt = 0;
  int          done_cnt = 0;
  int          acc_total = 0;
  int          acc_last = 0;
  bit          mem_auto = 1'b1;
  logic [30:0] model_sum = 31'd0;
  logic [30:0] sum_base = 31'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (resetn && bus.done) done_cnt++;

  // Memory model: checks each request against the scoreboard and replies two cycles later.
  initial begin
    word_t w;
    auto_reply = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && bus.mem_write_to_mem) begin
        req_cnt++;
        req_cyc = cyc;
        chk("digits_before_req", acc_total - acc_last, 11);
        acc_last = acc_total;
        chk("req_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          w = sb_q.pop_front();
          chk("req_addr", bus.addr_to_sel, w.addr);
          chk("req_sign", bus.write_sign_to_mem, w.sign);
          chk("req_data", bus.write_data_to_mem, w.data);
          if (mem_auto) begin
            @(negedge clk);
            @(negedge clk);
            chk("hold_addr", bus.addr_to_sel, w.addr);
            chk("hold_data", {bus.write_sign_to_mem, bus.write_data_to_mem}, {w.sign, w.data});
            chk("req_one_cycle", bus.mem_write_to_mem, 0);
            auto_reply = 1'b1;
            model_sum = model_sum + {w.sign, w.data};
            @(negedge clk);
            auto_reply = 1'b0;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [11:0] a, input logic [11:0] n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = a;
    bus.word_count = n;
    sum_base = model_sum;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic push_digit(input logic [2:0] d, input bit stall);
    int guard = 0;
    forever begin
      @(negedge clk);
      if (stall && $urandom_range(0, 2) == 0) begin
        bus.digit_valid = 1'b0;
      end else begin
        bus.digit_valid = 1'b1;
        bus.digit = d;
        if (bus.digit_ready) begin
          acc_total++;
          break;
        end
      end
      guard++;
      if (guard > 300) begin
        chk("digit_accept_timeout", bus.digit_ready, 1);
        break;
      end
    end
  endtask

  task automatic send_word(input logic [11:0] a, input logic s, input logic [29:0] d, input bit stall);
    logic [1:0] junk;
    word_t w;
    w.addr = a;
    w.sign = s;
    w.data = d;
    sb_q.push_back(w);
    junk = 2'($urandom_range(0, 3));
    push_digit({junk, s}, stall);
    for (int i = 1; i <= 10; i++) push_digit(d[32-3*i -: 3], stall);
  endtask

  task automatic end_digits();
    @(negedge clk);
    bus.digit_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [11:0] exp_addr, input bit check_lat);
    int n = 0;
    logic [30:0] exp_sum;
    while (bus.done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done, 1);
    if (check_lat) chk("done_latency", cyc - req_cyc, 3);
    chk("busy_during_done", bus.busy, 1);
    chk("final_addr", bus.addr_to_sel, exp_addr);
`ifdef IO_BLOCK_LOADER_CHECKSUM_EN
    exp_sum = model_sum - sum_base;
`else
    exp_sum = 31'd0;
`endif
    chk("checksum", bus.checksum, exp_sum);
    @(negedge clk);
    chk("done_fall", bus.done, 0);
    chk("busy_fall", bus.busy, 0);
  endtask

  logic [29:0] wdat[3];
  logic        wsgn[3];
  int          req0;
  int          done0;

  initial begin
    resetn = 1'b0;
    manual_reply = 1'b0;
    bus.start = 1'b0;
    bus.start_addr = 12'd0;
    bus.word_count = 12'd0;
    bus.digit_valid = 1'b0;
    bus.digit = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.digit_ready, 0);
    chk("rst_req", bus.mem_write_to_mem, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_word", {bus.addr_to_sel, bus.write_sign_to_mem, bus.write_data_to_mem}, 0);
    chk("rst_checksum", bus.checksum, 0);
    resetn = 1'b1;

    // Single word
    req0 = req_cnt;
    done0 = done_cnt;
    do_start(12'o0100, 12'd1);
    chk("start_busy", bus.busy, 1);
    chk("start_ready", bus.digit_ready, 1);
    send_word(12'o0100, 1'b1, 30'o1234567012, 1'b0);
    end_digits();
    wait_done(12'o0101, 1'b1);
    chk("single_req_count", req_cnt - req0, 1);
    chk("single_done_count", done_cnt - done0, 1);

    // Wrap-around, unstalled reference run
    for (int i = 0; i < 3; i++) begin
      wdat[i] = 30'($urandom);
      wsgn[i] = 1'($urandom_range(0, 1));
    end
    done0 = done_cnt;
    do_start(12'o7776, 12'd3);
    send_word(12'o7776, wsgn[0], wdat[0], 1'b0);
    send_word(12'o7777, wsgn[1], wdat[1], 1'b0);
    send_word(12'o0000, wsgn[2], wdat[2], 1'b0);
    end_digits();
    wait_done(12'o0001, 1'b1);
    chk("wrap_done_count", done_cnt - done0, 1);

    // Zero count
    req0 = req_cnt;
    done0 = done_cnt;
    do_start(12'o1234, 12'd0);
    chk("zero_ready", bus.digit_ready, 0);
    wait_done(12'o0001, 1'b0);
    chk("zero_ready_after", bus.digit_ready, 0);
    chk("zero_req_count", req_cnt - req0, 0);
    chk("zero_done_count", done_cnt - done0, 1);

    // Stalled run with the same words and an ignored second start
    done0 = done_cnt;
    do_start(12'o0200, 12'd3);
    send_word(12'o0200, wsgn[0], wdat[0], 1'b1);
    do_start(12'o0555, 12'd7);
    send_word(12'o0201, wsgn[1], wdat[1], 1'b1);
    send_word(12'o0202, wsgn[2], wdat[2], 1'b1);
    end_digits();
    wait_done(12'o0203, 1'b1);
    chk("stall_done_count", done_cnt - done0, 1);
    chk("stall_queue_empty", sb_q.size(), 0);

    // Checksum wrap: all-ones word plus one
    do_start(12'o0300, 12'd2);
    send_word(12'o0300, 1'b1, 30'o7777777777, 1'b0);
    send_word(12'o0301, 1'b0, 30'o0000000001, 1'b0);
    end_digits();
    wait_done(12'o0302, 1'b1);

    // Reset during WAIT, then a late reply
    mem_auto = 1'b0;
    do_start(12'o0400, 12'd2);
    send_word(12'o0400, 1'b1, 30'o0123456701, 1'b0);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.mem_write_to_mem && n < 50);
    end
    bus.digit_valid = 1'b0;
    chk("abort_req_seen", bus.mem_write_to_mem, 1);
    @(negedge clk);
    chk("abort_in_wait", bus.busy, 1);
    req0 = req_cnt;
    #2 resetn = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_req", bus.mem_write_to_mem, 0);
    chk("abort_ready", bus.digit_ready, 0);
    chk("abort_word", {bus.addr_to_sel, bus.write_sign_to_mem, bus.write_data_to_mem}, 0);
    chk("abort_checksum", bus.checksum, 0);
    @(negedge clk);
    resetn = 1'b1;
    manual_reply = 1'b1;
    @(negedge clk);
    manual_reply = 1'b0;
    @(negedge clk);
    chk("late_reply_busy", bus.busy, 0);
    chk("late_reply_addr", bus.addr_to_sel, 0);
    chk("late_reply_done", bus.done, 0);
    chk("abort_no_req", req_cnt - req0, 0);
    mem_auto = 1'b1;

    // Recovery after abort
    acc_total = acc_last;
    do_start(12'o0010, 12'd1);
    send_word(12'o0010, 1'b0, 30'o7070707070, 1'b0);
    end_digits();
    wait_done(12'o0011, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
